// File: rtl/stateful_action_exec.sv
// Stateful action executor: decodes the per-packet action, stamps the state byte
// into the packet word, and forwards through a FIFO to a valid/ready output.
module stateful_action_exec #(
  parameter int         FIFO_DEPTH_BITS  = 4,
  parameter int         STATE_LSB        = 504,
  parameter logic [7:0] DEFAULT_PORT_MAP = 8'h80
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pkt_vld_in,
  input  logic [511:0] pkt_data_in,
  input  logic [15:0]  action_in,
  input  logic [7:0]   state_in,
  output logic         pkt_vld_out,
  output logic [511:0] pkt_data_out,
  output logic [7:0]   port_map_out,
  input  logic         pkt_rdy_in,
  output logic [31:0]  fwd_cnt,
  output logic [31:0]  drop_cnt,
  output logic [31:0]  ovf_cnt,
  output logic         fifo_empty
);

  localparam int               DEPTH   = 1 << FIFO_DEPTH_BITS;
  localparam int               PW      = FIFO_DEPTH_BITS + 1;
  localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);

  // Decode-stage combinational results
  logic         w_fwd;
  logic [7:0]   w_map;
  logic [511:0] w_stamped;

  // Decode-stage registers
  logic         r_s1_vld;
  logic         r_s1_fwd;
  logic [7:0]   r_s1_map;
  logic [511:0] r_s1_data;

  // FIFO storage and pointers (one extra pointer bit separates full from empty)
  logic [519:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] w_count;
  logic          w_empty;
  logic          w_rd;
  logic          w_full;
  logic          w_wr;

  // Output register and counters
  logic         r_vld_out;
  logic [511:0] r_data_out;
  logic [7:0]   r_map_out;
  logic [31:0]  r_fwd_cnt;
  logic [31:0]  r_drop_cnt;
  logic [31:0]  r_ovf_cnt;

  // Action decode and state stamping
  always_comb begin
    w_fwd     = 1'b0;
    w_map     = 8'h00;
    w_stamped = pkt_data_in;
    w_stamped[STATE_LSB +: 8] = state_in;
    if (action_in[15:8] != 8'h00) begin
      w_fwd = 1'b1;
      w_map = action_in[15:8];
    end else if (action_in[7:0] != 8'h00) begin
      w_fwd = 1'b1;
      w_map = DEFAULT_PORT_MAP;
    end else begin
      w_fwd = 1'b0;
      w_map = 8'h00;
    end
  end

  // Decode-stage pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_fwd  <= 1'b0;
      r_s1_map  <= 8'h00;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= pkt_vld_in;
      if (pkt_vld_in) begin
        r_s1_fwd  <= w_fwd;
        r_s1_map  <= w_map;
        r_s1_data <= w_stamped;
      end
    end
  end

  // A read in the same cycle frees a slot, so full only blocks when nothing drains.
  always_comb begin
    w_count = r_wptr - r_rptr;
    w_empty = (r_wptr == r_rptr);
    w_rd    = (~r_vld_out | pkt_rdy_in) & ~w_empty;
    w_full  = (w_count == DEPTH_P) & ~w_rd;
    w_wr    = r_s1_vld & r_s1_fwd & ~w_full;
  end

  // FIFO storage write; contents are don't-care outside the pointer window
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[FIFO_DEPTH_BITS-1:0]] <= {r_s1_map, r_s1_data};
    end
  end

  // FIFO pointers and packet counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fwd_cnt  <= 32'd0;
      r_drop_cnt <= 32'd0;
      r_ovf_cnt  <= 32'd0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PW'(1);
      if (w_rd) r_rptr <= r_rptr + PW'(1);
      if (r_s1_vld) begin
        if (!r_s1_fwd)   r_drop_cnt <= r_drop_cnt + 32'd1;
        else if (w_full) r_ovf_cnt  <= r_ovf_cnt + 32'd1;
        else             r_fwd_cnt  <= r_fwd_cnt + 32'd1;
      end
    end
  end

  // Output register: refill from the FIFO head when empty or transferring
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_out  <= 1'b0;
      r_data_out <= '0;
      r_map_out  <= 8'h00;
    end else if (w_rd) begin
      r_vld_out                 <= 1'b1;
      {r_map_out, r_data_out}   <= r_mem[r_rptr[FIFO_DEPTH_BITS-1:0]];
    end else if (pkt_rdy_in) begin
      r_vld_out <= 1'b0;
    end
  end

  assign pkt_vld_out  = r_vld_out;
  assign pkt_data_out = r_data_out;
  assign port_map_out = r_map_out;
  assign fwd_cnt      = r_fwd_cnt;
  assign drop_cnt     = r_drop_cnt;
  assign ovf_cnt      = r_ovf_cnt;
  assign fifo_empty   = w_empty;

endmodule

// File: tb/tb_stateful_action_exec.sv
// Directed bench for stateful_action_exec: table of single-packet vectors plus
// hand-written backpressure, overflow, full-with-read and reset sequences.
module tb_stateful_action_exec;

  logic         clk;
  logic         reset;
  logic         pkt_vld_in;
  logic [511:0] pkt_data_in;
  logic [15:0]  action_in;
  logic [7:0]   state_in;
  logic         pkt_vld_out;
  logic [511:0] pkt_data_out;
  logic [7:0]   port_map_out;
  logic         pkt_rdy_in;
  logic [31:0]  fwd_cnt;
  logic [31:0]  drop_cnt;
  logic [31:0]  ovf_cnt;
  logic         fifo_empty;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [511:0] data;
    logic [15:0]  action;
    logic [7:0]   state;
    logic         exp_vld;
    logic [7:0]   exp_map;
    logic [7:0]   exp_hi;
    logic [7:0]   exp_lo;
    logic [31:0]  exp_fwd;
    logic [31:0]  exp_drop;
  } vec_t;

  vec_t vecs [7];

  stateful_action_exec dut (
    .clk          (clk),
    .reset        (reset),
    .pkt_vld_in   (pkt_vld_in),
    .pkt_data_in  (pkt_data_in),
    .action_in    (action_in),
    .state_in     (state_in),
    .pkt_vld_out  (pkt_vld_out),
    .pkt_data_out (pkt_data_out),
    .port_map_out (port_map_out),
    .pkt_rdy_in   (pkt_rdy_in),
    .fwd_cnt      (fwd_cnt),
    .drop_cnt     (drop_cnt),
    .ovf_cnt      (ovf_cnt),
    .fifo_empty   (fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    pkt_vld_in = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_vld",   pkt_vld_out,  1'b0);
    chk("rst_data",  pkt_data_out, 512'h0);
    chk("rst_map",   port_map_out, 8'h00);
    chk("rst_fwd",   fwd_cnt,      32'd0);
    chk("rst_drop",  drop_cnt,     32'd0);
    chk("rst_ovf",   ovf_cnt,      32'd0);
    chk("rst_empty", fifo_empty,   1'b1);
  endtask

  task automatic send_word(input logic [511:0] d, input logic [15:0] a, input logic [7:0] s);
    pkt_vld_in  = 1'b1;
    pkt_data_in = d;
    action_in   = a;
    state_in    = s;
  endtask

  // One packet with ready high: absent at N+2, present for exactly one cycle at N+3
  task automatic apply_vec(input vec_t v);
    logic [511:0] exp_word;
    exp_word = v.data;
    exp_word[511:504] = v.state;
    send_word(v.data, v.action, v.state);
    tick();
    pkt_vld_in = 1'b0;
    tick();
    chk("lat2_vld", pkt_vld_out, 1'b0);
    tick();
    chk("lat3_vld", pkt_vld_out, v.exp_vld);
    if (v.exp_vld) begin
      chk("map",     port_map_out,          v.exp_map);
      chk("state_b", pkt_data_out[511:504], v.exp_hi);
      chk("low_b",   pkt_data_out[7:0],     v.exp_lo);
      chk("word",    pkt_data_out,          exp_word);
    end
    chk("fwd_cnt",  fwd_cnt,  v.exp_fwd);
    chk("drop_cnt", drop_cnt, v.exp_drop);
    tick();
    chk("after_vld", pkt_vld_out, 1'b0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{512'hA5, 16'h0300, 8'h02, 1'b1, 8'h03, 8'h02, 8'hA5, 32'd1, 32'd0};
    vecs[1] = '{512'h5A, 16'h00ff, 8'h01, 1'b1, 8'h80, 8'h01, 8'h5A, 32'd2, 32'd0};
    vecs[2] = '{512'h77, 16'h0000, 8'h09, 1'b0, 8'h00, 8'h00, 8'h00, 32'd2, 32'd1};
    vecs[3] = '{{8'hFF, 496'h0, 8'h3C}, 16'h8001, 8'h00, 1'b1, 8'h80, 8'h00, 8'h3C, 32'd3, 32'd1};
    vecs[4] = '{{512{1'b1}}, 16'h0100, 8'hC3, 1'b1, 8'h01, 8'hC3, 8'hFF, 32'd4, 32'd1};
    vecs[5] = '{512'h11, 16'h0000, 8'h44, 1'b0, 8'h00, 8'h00, 8'h00, 32'd4, 32'd2};
    vecs[6] = '{512'h22, 16'hFF00, 8'h55, 1'b1, 8'hFF, 8'h55, 8'h22, 32'd5, 32'd2};

    reset       = 1'b1;
    pkt_vld_in  = 1'b0;
    pkt_data_in = '0;
    action_in   = 16'h0000;
    state_in    = 8'h00;
    pkt_rdy_in  = 1'b1;
    tick();
    do_reset();

    // Single-packet vectors, ready held high
    for (int i = 0; i < 7; i++) apply_vec(vecs[i]);
    chk("tbl_ovf", ovf_cnt, 32'd0);

    // Backpressure: first word holds stable, then three back-to-back transfers
    do_reset();
    pkt_rdy_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      send_word(512'(i), 16'h0200, 8'h00);
      tick();
    end
    pkt_vld_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld",  pkt_vld_out,  1'b1);
      chk("bp_data", pkt_data_out, 512'h1);
      chk("bp_map",  port_map_out, 8'h02);
      tick();
    end
    chk("bp_hold", pkt_data_out, 512'h1);
    pkt_rdy_in = 1'b1;
    tick();
    chk("bp_w2", pkt_data_out, 512'h2);
    chk("bp_v2", pkt_vld_out,  1'b1);
    tick();
    chk("bp_w3", pkt_data_out, 512'h3);
    chk("bp_v3", pkt_vld_out,  1'b1);
    tick();
    chk("bp_end", pkt_vld_out, 1'b0);

    // Overflow: 20 words into a 16-deep FIFO plus the output register
    do_reset();
    pkt_rdy_in = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      send_word(512'(i), 16'h0400, 8'h00);
      tick();
    end
    pkt_vld_in = 1'b0;
    repeat (3) tick();
    chk("ovf_fwd",   fwd_cnt,    32'd17);
    chk("ovf_ovf",   ovf_cnt,    32'd3);
    chk("ovf_drop",  drop_cnt,   32'd0);
    chk("ovf_nempt", fifo_empty, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      chk("drain_vld",  pkt_vld_out,  1'b1);
      chk("drain_data", pkt_data_out, 512'(k));
      if (k == 1) pkt_rdy_in = 1'b1;
      tick();
    end
    chk("drain_end",   pkt_vld_out, 1'b0);
    chk("drain_empty", fifo_empty,  1'b1);

    // Full FIFO: a write landing on the same edge as a read must be accepted
    do_reset();
    pkt_rdy_in = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      send_word(512'(i), 16'h0400, 8'h00);
      tick();
    end
    pkt_vld_in = 1'b0;
    repeat (3) tick();
    chk("full_fwd", fwd_cnt, 32'd17);
    send_word(512'd18, 16'h0400, 8'h00);
    tick();
    pkt_vld_in = 1'b0;
    chk("full_head", pkt_data_out, 512'h1);
    pkt_rdy_in = 1'b1;
    tick();
    chk("full_ovf",  ovf_cnt,      32'd0);
    chk("full_fwd2", fwd_cnt,      32'd18);
    chk("full_w2",   pkt_data_out, 512'h2);
    for (int k = 3; k <= 18; k++) begin
      tick();
      chk("full_vld",  pkt_vld_out,  1'b1);
      chk("full_data", pkt_data_out, 512'(k));
    end
    tick();
    chk("full_end", pkt_vld_out, 1'b0);

    // Reset mid-stream, with a packet sitting in the decode stage
    do_reset();
    pkt_rdy_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_word(512'(i), 16'h0500, 8'h00);
      tick();
    end
    pkt_vld_in = 1'b0;
    repeat (3) tick();
    chk("mid_nempt", fifo_empty, 1'b0);
    chk("mid_vld",   pkt_vld_out, 1'b1);
    send_word(512'h66, 16'h0500, 8'h00);
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    pkt_vld_in = 1'b0;
    chk("mrst_vld",   pkt_vld_out, 1'b0);
    chk("mrst_fwd",   fwd_cnt,     32'd0);
    chk("mrst_drop",  drop_cnt,    32'd0);
    chk("mrst_ovf",   ovf_cnt,     32'd0);
    chk("mrst_empty", fifo_empty,  1'b1);
    chk("mrst_map",   port_map_out, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_idle_vld", pkt_vld_out, 1'b0);
      chk("mrst_idle_fwd", fwd_cnt,     32'd0);
    end
    pkt_rdy_in = 1'b1;
    v = '{512'h99, 16'h0600, 8'h7E, 1'b1, 8'h06, 8'h7E, 8'h99, 32'd1, 32'd0};
    apply_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stateful_action_exec.md
Name: stateful_action_exec

Overview:
- Downstream consumer of the stateful lookup stage's outputs: pkt_vld/pkt_data/action/state.
- Decodes the 16-bit action per packet and stamps the 8-bit state into the packet word.
- Forwards the packet with an egress port map over a valid/ready interface, or drops it.
- The upstream stage has no backpressure, so this block absorbs bursts in an internal FIFO and counts forwards, drops and overflows.

Parameters:
- FIFO_DEPTH_BITS, 4: log2 of the output FIFO depth (16 entries of 512+8 bits).
- STATE_LSB, 504: bit position in the 512-bit word where state_in is written (8 bits, STATE_LSB+7 <= 511).
- DEFAULT_PORT_MAP, 8'h80: port map used for state-update-only packets (CPU port).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- pkt_vld_in  input  1  one 512-bit packet word valid this cycle; no backpressure
- pkt_data_in  input  512  packet word
- action_in  input  16  [15:8] egress port map, [7:0] state-update opcode
- state_in  input  8  state value to stamp
- pkt_vld_out  output  1  output word valid
- pkt_data_out  output  512  packet word with state stamped
- port_map_out  output  8  egress port bitmap for pkt_data_out
- pkt_rdy_in  input  1  downstream ready
- fwd_cnt  output  32  packets enqueued for forwarding
- drop_cnt  output  32  packets dropped by action
- ovf_cnt  output  32  packets dropped because the FIFO was full
- fifo_empty  output  1  FIFO empty status

Behaviour:

Reset:
- pkt_vld_out=0, pkt_data_out=0, port_map_out=0, all counters=0, fifo_empty=1.
- FIFO pointers cleared; any in-flight or decode-stage packet is discarded.

Stage 1, decode (registered on pkt_vld_in):
- If action_in[15:8]!=0: FWD, map=action_in[15:8].
- Else if action_in[7:0]!=0: FWD, map=DEFAULT_PORT_MAP.
- Else: DROP.
- Word stamped: data with bits [STATE_LSB+7:STATE_LSB] replaced by state_in; all other bits unchanged.

Stage 2, enqueue (the cycle after decode):
- FWD and FIFO not full: write {map, stamped data}; fwd_cnt+1.
- FWD and FIFO full: discard; ovf_cnt+1; FIFO contents untouched.
- DROP: discard; drop_cnt+1.
- Counters wrap modulo 2^32.

FIFO:
- Full means 2^FIFO_DEPTH_BITS entries held.
- Full is evaluated on the pre-write occupancy, counting a same-cycle read as freeing a slot. A write and read in the same cycle at full therefore succeeds.

Output register (valid/ready):
- Transfer occurs when pkt_vld_out & pkt_rdy_in.
- Output register loads from the FIFO head when it is empty or transferring, and the FIFO is non-empty.
- While pkt_vld_out=1 and pkt_rdy_in=0, pkt_data_out and port_map_out hold stable.
- pkt_vld_out is never deasserted without a transfer.
- Back-to-back transfers sustain 1 word/cycle.

Latency:
- pkt_vld_in at cycle N, with FIFO empty and ready high: pkt_vld_out=1 at N+3 (decode N+1, FIFO write N+2, output load N+3).
- Order is strictly preserved.

Simultaneous events:
- Input decode, FIFO write, FIFO read and output transfer may all occur in one cycle.
- pkt_rdy_in is don't-care when pkt_vld_out=0.

Reset mid-operation:
- Takes effect at the next clock edge, overriding all other activity.
- The first post-reset input is processed normally.

Test Plan:
1. Forward to port map: reset, pkt_rdy_in=1; one word with data=512'h0...A5, action=16'h0300, state=8'h02 -> at N+3 pkt_vld_out=1, port_map_out=8'h03, data[511:504]=8'h02, data[7:0]=8'hA5; fwd_cnt=1.
2. State-update-only and drop: action=16'h00ff, state=8'h01 -> port_map_out=8'h80, data[511:504]=8'h01. Then action=16'h0000 -> no output; drop_cnt=1.
3. Backpressure hold: pkt_rdy_in=0, send 3 FWD words with data 1,2,3 -> pkt_vld_out=1 with word 1 stable for 10 cycles. Raise ready -> words 1,2,3 on consecutive cycles, then pkt_vld_out=0.
4. Overflow: pkt_rdy_in=0, 20 consecutive FWD words with FIFO_DEPTH_BITS=4 -> fwd_cnt=17 (16 in FIFO + 1 in output register), ovf_cnt=3. Drain yields the first 17 words in order.
5. Full plus simultaneous read: FIFO full, pkt_rdy_in=1 while one new FWD word is written in the same cycle -> write accepted, ovf_cnt unchanged, order preserved.
6. Reset mid-stream: 5 words queued, pkt_rdy_in=0, assert reset 1 cycle -> next cycle pkt_vld_out=0, all counters=0, fifo_empty=1. Then a new word is forwarded with latency 3.
